// File: rtl/ysyx_22050019_stage_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ysyx_22050019_stage_buf                                       |
// | Brief    : valid/ready pipeline-stage buffer with bubble zeroing and a   |
// |            saturating back-pressure counter. Define                      |
// |            YSYX_22050019_STAGE_SKID_EN for a 2-entry skid buffer with a  |
// |            registered in_ready_o.                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ysyx_22050019_stage_buf #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic [CNT_W-1:0]  bp_cnt_o
);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_FULL  = 2'd1;
`ifdef YSYX_22050019_STAGE_SKID_EN
  localparam logic [1:0] c_SKID  = 2'd2;
`endif
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_out_valid;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_fire;
  logic [PC_W-1:0]   r_main_pc;
  logic [INST_W-1:0] r_main_inst;
`ifdef YSYX_22050019_STAGE_SKID_EN
  logic [PC_W-1:0]   r_skid_pc;
  logic [INST_W-1:0] r_skid_inst;
`endif
  logic [CNT_W-1:0]  r_bp_cnt;

  assign w_accept = in_valid_i && w_in_ready;
  assign w_fire   = w_out_valid && out_ready_i;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= c_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = c_EMPTY;
    end else begin
      case (r_state)
        c_EMPTY: if (w_accept) w_state_nxt = c_FULL;
`ifdef YSYX_22050019_STAGE_SKID_EN
        c_FULL: begin
          if (w_accept && !w_fire)      w_state_nxt = c_SKID;
          else if (!w_accept && w_fire) w_state_nxt = c_EMPTY;
        end
        c_SKID:  if (w_fire) w_state_nxt = c_FULL;
`else
        // Accepting while FULL always coincides with a fire, so FULL is kept.
        c_FULL:  if (!w_accept && w_fire) w_state_nxt = c_EMPTY;
`endif
        default: w_state_nxt = c_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_out_valid = (r_state != c_EMPTY);
`ifdef YSYX_22050019_STAGE_SKID_EN
    w_in_ready  = (r_state != c_SKID);
`else
    w_in_ready  = !w_out_valid || out_ready_i;
`endif
    out_valid_o = w_out_valid;
    in_ready_o  = w_in_ready;
    pc_o        = w_out_valid ? r_main_pc : '0;
    inst_o      = w_out_valid ? r_main_inst : '0;
    bp_cnt_o    = r_bp_cnt;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_main_pc   <= '0;
      r_main_inst <= '0;
`ifdef YSYX_22050019_STAGE_SKID_EN
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
`endif
    end else if (flush_i) begin
      r_main_pc   <= '0;
      r_main_inst <= '0;
`ifdef YSYX_22050019_STAGE_SKID_EN
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
`endif
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (w_accept) begin
            r_main_pc   <= pc_i;
            r_main_inst <= inst_i;
          end
        end
        c_FULL: begin
          if (w_accept && w_fire) begin
            r_main_pc   <= pc_i;
            r_main_inst <= inst_i;
`ifdef YSYX_22050019_STAGE_SKID_EN
          end else if (w_accept) begin
            r_skid_pc   <= pc_i;
            r_skid_inst <= inst_i;
`endif
          end else if (w_fire) begin
            r_main_pc   <= '0;
            r_main_inst <= '0;
          end
        end
`ifdef YSYX_22050019_STAGE_SKID_EN
        c_SKID: begin
          if (w_fire) begin
            r_main_pc   <= r_skid_pc;
            r_main_inst <= r_skid_inst;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Stall counter deliberately ignores flush_i; only reset clears it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_bp_cnt <= '0;
    end else if (w_out_valid && !out_ready_i && (r_bp_cnt != c_CNT_MAX)) begin
      r_bp_cnt <= r_bp_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22050019_stage_buf.md
# ysyx_22050019_stage_buf

Parametrised pipeline-stage buffer for the ysyx_22050019 core, used between adjacent stages (IF→ID first, then ID→EX, EX→MEM). It replaces hard stall/flush control with a valid/ready handshake, adds configurable PC/instruction widths, and drops injected bubbles as zeroed payloads. An optional 2-entry skid buffer allows full throughput with a registered upstream ready. A saturating back-pressure counter feeds the performance monitor.

## Interface
- PC_W, 64, width of PC payload
- INST_W, 32, width of instruction payload
- CNT_W, 16, width of back-pressure cycle counter
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-high (port keeps the codebase name; asserted = 1)
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  block can accept payload this cycle
- pc_i  in  PC_W  upstream PC
- inst_i  in  INST_W  upstream instruction
- flush_i  in  1  discard all held and incoming payloads
- out_valid_o  out  1  downstream payload valid (commit flag)
- out_ready_i  in  1  downstream accepts payload
- pc_o  out  PC_W  held PC; 0 when out_valid_o=0
- inst_o  out  INST_W  held instruction; 0 when out_valid_o=0
- bp_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating

## Operation
- Accept: in_valid_i && in_ready_o at rising edge. Fire: out_valid_o && out_ready_i at rising edge.
- Storage: main entry (drives outputs) plus, with skid enabled, skid entry.
- States (skid enabled): EMPTY, FULL (main valid), SKID (main+skid valid).
  - EMPTY: accept → FULL, main ← input.
  - FULL: accept & fire → FULL, main ← input; accept & !fire → SKID, skid ← input; !accept & fire → EMPTY; else hold.
  - SKID: fire → FULL, main ← skid; else hold. No accept possible.
- in_ready_o (skid enabled) = state != SKID; driven only from registered state, no path from out_ready_i.
- Flush: flush_i=1 at an edge forces EMPTY, clears both entries to 0; any payload accepted that cycle is dropped. Flush has priority over accept and fire.
- Payload zeroing: pc_o/inst_o are 0 whenever out_valid_o=0 (inst 0 = bubble), stored registers cleared on drain and flush.
- bp_cnt_o increments by 1 each edge with out_valid_o=1 && out_ready_i=0; holds at 2^CNT_W−1; never wraps; not cleared by flush_i.
- Order preserved: payloads leave in acceptance order; no duplication, no loss except by flush_i.

## Timing
- Reset (rst_n=1, async): state EMPTY, out_valid_o=0, pc_o=0, inst_o=0, bp_cnt_o=0, in_ready_o=1. Assertion mid-transfer discards all entries immediately, without waiting for clk.
- Latency: payload accepted at edge N is on outputs with out_valid_o=1 after edge N.
- Throughput: 1 payload/cycle sustained when out_ready_i=1.
- Back-pressure (skid): after out_ready_i drops, at most one further payload is absorbed; in_ready_o falls the cycle after the skid entry fills, and rises the cycle after SKID → FULL.
- Flush: out_valid_o=0 and in_ready_o=1 the cycle after the flush edge.

## Configuration
- YSYX_22050019_STAGE_SKID_EN defined: 2-entry skid buffer, 3-state machine as above, registered in_ready_o.
- Not defined: main entry only, states EMPTY/FULL; in_ready_o = !out_valid_o || out_ready_i (combinational from out_ready_i); accept while FULL requires simultaneous fire; all other rules (flush, zeroing, counter, reset) identical.

## Test plan
- Reset: hold rst_n=1 mid-stream with out_valid_o=1 → outputs 0, bp_cnt_o=0, in_ready_o=1 before next clk edge.
- Streaming: 8 payloads pc=0x80000000+4k, inst=0x00000013, out_ready_i=1 → each appears 1 cycle after accept, 8 consecutive valid cycles, order preserved.
- Back-pressure (skid): out_ready_i=0 for 3 cycles while in_valid_i=1 → exactly 2 payloads held, in_ready_o=0, bp_cnt_o=3; release → both delivered in order, no loss.
- Flush in SKID with in_valid_i=1 → next cycle out_valid_o=0, pc_o=0, inst_o=0, in_ready_o=1; neither held nor incoming payload ever appears.
- Counter saturation with CNT_W=4: 20 stalled cycles → bp_cnt_o=15, stays 15.
- Macro undefined: out_ready_i=0 while FULL → in_ready_o=0 in the same cycle; out_ready_i=1 with in_valid_i=1 → replace-in-place, 1 payload/cycle.
